// File: rtl/dnn_pkg.sv
// Shared types and constants for the DNN layer stream controller.
// Vectors are packed so that element k sits at bits [k*DATA_W +: DATA_W].
package dnn_pkg;
    localparam int DATA_W = 16;
    localparam int VEC_N  = 8;

    typedef enum logic [2:0] {
        LOAD = 3'd0,
        CLR  = 3'd1,
        RUN  = 3'd2,
        CAP  = 3'd3,
        SEND = 3'd4
    } state_t;

    typedef logic [VEC_N-1:0][DATA_W-1:0] vec_t;

    function automatic logic [DATA_W-1:0] vec_sel(input vec_t v, input logic [2:0] idx);
        return v[idx];
    endfunction
endpackage

// File: rtl/dnn_stream_ctrl_if.sv
// Input and output valid/ready streams of the layer controller.
// The master side feeds input beats and accepts output beats; the slave side is the controller.
interface dnn_stream_ctrl_if;
    import dnn_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/dnn_vec_buf.sv
// 8 x 16 register bank with indexed single-element write and full parallel load.
// A parallel load takes priority over an indexed write in the same cycle.
module dnn_vec_buf
    import dnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [2:0]        wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              ld_en,
    input  vec_t              ld_data,
    output vec_t              q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld_en) begin
            q <= ld_data;
        end else if (wr_en) begin
            q[wr_idx] <= wr_data;
        end
    end
endmodule

// File: rtl/dnn_stream_ctrl.sv
// Stream front/back-end for the 8x8 DNN layer: gathers an input vector, sequences
// clr/en on the datapath, captures the activations and replays them downstream.
module dnn_stream_ctrl
    import dnn_pkg::*;
#(
    parameter int unsigned LAT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    dnn_stream_ctrl_if.slave    sif,
    output logic [DATA_W-1:0]   x0, x1, x2, x3, x4, x5, x6, x7,
    output logic                dp_en,
    output logic                dp_clr,
    input  logic [DATA_W-1:0]   a0, a1, a2, a3, a4, a5, a6, a7,
    output logic                busy,
    output logic                err_last
);
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t         state;
    logic [2:0]     in_idx;
    logic [2:0]     out_idx;
    logic [CW-1:0]  run_cnt;
    logic           s_hs;
    vec_t           in_q;
    vec_t           out_q;
    vec_t           a_vec;

    // s_ready is only ever high in LOAD, so a handshake implies LOAD.
    assign s_hs  = sif.s_valid && sif.s_ready;
    assign a_vec = {a7, a6, a5, a4, a3, a2, a1, a0};

    dnn_vec_buf u_in_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (s_hs),
        .wr_idx  (in_idx),
        .wr_data (sif.s_data),
        .ld_en   (1'b0),
        .ld_data ('0),
        .q       (in_q)
    );

    dnn_vec_buf u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (1'b0),
        .wr_idx  (3'd0),
        .wr_data ('0),
        .ld_en   (state == CAP),
        .ld_data (a_vec),
        .q       (out_q)
    );

    assign {x7, x6, x5, x4, x3, x2, x1, x0} = in_q;
    assign sif.m_data = vec_sel(out_q, out_idx);
    assign busy       = !(state == LOAD && in_idx == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            in_idx      <= '0;
            out_idx     <= '0;
            run_cnt     <= '0;
            sif.s_ready <= 1'b1;
            sif.m_valid <= 1'b0;
            sif.m_last  <= 1'b0;
            dp_en       <= 1'b0;
            dp_clr      <= 1'b0;
            err_last    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_hs) begin
                        if (sif.s_last != (in_idx == 3'(VEC_N - 1))) begin
                            err_last <= 1'b1;
                        end
                        if (in_idx == 3'(VEC_N - 1)) begin
                            in_idx      <= '0;
                            sif.s_ready <= 1'b0;
                            dp_clr      <= 1'b1;
                            state       <= CLR;
                        end else begin
                            in_idx <= in_idx + 3'd1;
                        end
                    end
                end
                CLR: begin
                    dp_clr  <= 1'b0;
                    dp_en   <= 1'b1;
                    run_cnt <= CW'(LAT - 1);
                    state   <= RUN;
                end
                RUN: begin
                    if (run_cnt == '0) begin
                        dp_en <= 1'b0;
                        state <= CAP;
                    end else begin
                        run_cnt <= run_cnt - 1'b1;
                    end
                end
                CAP: begin
                    out_idx     <= '0;
                    sif.m_valid <= 1'b1;
                    sif.m_last  <= 1'b0;
                    state       <= SEND;
                end
                SEND: begin
                    if (sif.m_ready) begin
                        if (out_idx == 3'(VEC_N - 1)) begin
                            out_idx     <= '0;
                            sif.m_valid <= 1'b0;
                            sif.m_last  <= 1'b0;
                            sif.s_ready <= 1'b1;
                            state       <= LOAD;
                        end else begin
                            out_idx    <= out_idx + 3'd1;
                            sif.m_last <= (out_idx == 3'(VEC_N - 2));
                        end
                    end
                end
                default: begin
                    state       <= LOAD;
                    sif.s_ready <= 1'b1;
                    sif.m_valid <= 1'b0;
                    dp_en       <= 1'b0;
                    dp_clr      <= 1'b0;
                end
            endcase
        end
    end
endmodule
